// File: rtl/veerwolf_board_io.sv
// Board I/O conditioning for VeeRwolf: switch sync/debounce with edge pulses, LED pipeline, glitch-free UART TX mux.
// Optional heartbeat on the top LED is enabled by defining VEERWOLF_BOARD_IO_HEARTBEAT_EN.
module veerwolf_board_io #(
  parameter int SW_WIDTH         = 16,
  parameter int LED_WIDTH        = 16,
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int UART_SEL_BIT     = 0,
  parameter int IDLE_CYCLES      = 1000,
  parameter int HEARTBEAT_CYCLES = 25000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SW_WIDTH-1:0]  i_sw,
  output logic [SW_WIDTH-1:0]  o_sw,
  output logic [SW_WIDTH-1:0]  o_sw_rise,
  output logic [SW_WIDTH-1:0]  o_sw_fall,
  input  logic [LED_WIDTH-1:0] i_led,
  output logic [LED_WIDTH-1:0] o_led,
  input  logic                 i_tx_a,
  input  logic                 i_tx_b,
  output logic                 o_uart_tx,
  output logic                 o_tx_sel
);

  localparam int DB_CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_CW-1:0] DB_ONE  = DB_CW'(1);
  localparam int IDLE_CW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_CW-1:0] IDLE_LAST = IDLE_CW'(IDLE_CYCLES - 1);
  localparam logic [IDLE_CW-1:0] IDLE_ONE  = IDLE_CW'(1);

  typedef enum logic [0:0] {
    ST_ACTIVE = 1'b0,
    ST_DRAIN  = 1'b1
  } tx_state_e;

  logic [SW_WIDTH-1:0]  sync_r [SYNC_STAGES];
  logic [SW_WIDTH-1:0]  sw_s;
  logic [SW_WIDTH-1:0]  sw_r;
  logic [SW_WIDTH-1:0]  rise_r;
  logic [SW_WIDTH-1:0]  fall_r;
  logic [DB_CW-1:0]     db_cnt_r [SW_WIDTH];
  logic [LED_WIDTH-1:0] led_p1_r;
  logic [LED_WIDTH-1:0] led_p2_r;
  logic [LED_WIDTH-1:0] led_out_s;
  tx_state_e            state_r;
  tx_state_e            state_nxt_s;
  logic                 sel_r;
  logic                 sel_nxt_s;
  logic [IDLE_CW-1:0]   idle_r;
  logic [IDLE_CW-1:0]   idle_nxt_s;
  logic                 uart_tx_r;
  logic                 req_s;
  logic                 both_idle_s;

  // Metastability chain: raw switches are asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= '0;
      end
    end else begin
      sync_r[0] <= i_sw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign sw_s = sync_r[SYNC_STAGES-1];

  // Per-channel debounce: a change is accepted only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_r   <= '0;
      rise_r <= '0;
      fall_r <= '0;
      for (int i = 0; i < SW_WIDTH; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SW_WIDTH; i++) begin
        if (sw_s[i] == sw_r[i]) begin
          db_cnt_r[i] <= '0;
          rise_r[i]   <= 1'b0;
          fall_r[i]   <= 1'b0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          sw_r[i]     <= sw_s[i];
          db_cnt_r[i] <= '0;
          rise_r[i]   <= sw_s[i];
          fall_r[i]   <= ~sw_s[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
          rise_r[i]   <= 1'b0;
          fall_r[i]   <= 1'b0;
        end
      end
    end
  end

  assign o_sw      = sw_r;
  assign o_sw_rise = rise_r;
  assign o_sw_fall = fall_r;

  // Two-stage LED output pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_p1_r <= '0;
      led_p2_r <= '0;
    end else begin
      led_p1_r <= i_led;
      led_p2_r <= led_p1_r;
    end
  end

`ifdef VEERWOLF_BOARD_IO_HEARTBEAT_EN
  localparam int HB_CW = $clog2(HEARTBEAT_CYCLES + 1);
  localparam logic [HB_CW-1:0] HB_LAST = HB_CW'(HEARTBEAT_CYCLES - 1);
  localparam logic [HB_CW-1:0] HB_ONE  = HB_CW'(1);

  logic [HB_CW-1:0] hb_cnt_r;
  logic             hb_r;

  // Free-running heartbeat toggling every HEARTBEAT_CYCLES cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt_r <= '0;
      hb_r     <= 1'b0;
    end else if (hb_cnt_r == HB_LAST) begin
      hb_cnt_r <= '0;
      hb_r     <= ~hb_r;
    end else begin
      hb_cnt_r <= hb_cnt_r + HB_ONE;
    end
  end

  // Top LED shows the heartbeat instead of the core value
  always_comb begin
    led_out_s                = led_p2_r;
    led_out_s[LED_WIDTH-1]   = hb_r;
  end
`else
  // All LEDs come straight from the pipeline
  always_comb begin
    led_out_s = led_p2_r;
  end
`endif

  assign o_led = led_out_s;

  assign req_s       = sw_r[UART_SEL_BIT];
  assign both_idle_s = i_tx_a & i_tx_b;

  // TX source FSM state, selection, idle counter and registered pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_ACTIVE;
      sel_r     <= 1'b0;
      idle_r    <= '0;
      uart_tx_r <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      sel_r     <= sel_nxt_s;
      idle_r    <= idle_nxt_s;
      uart_tx_r <= sel_r ? i_tx_b : i_tx_a;
    end
  end

  // Switch source only after both lines have been idle long enough to be between frames
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    idle_nxt_s  = idle_r;
    case (state_r)
      ST_ACTIVE: begin
        if (req_s != sel_r) begin
          state_nxt_s = ST_DRAIN;
          idle_nxt_s  = '0;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_DRAIN: begin
        if (req_s == sel_r) begin
          state_nxt_s = ST_ACTIVE;
          idle_nxt_s  = '0;
        end else if (both_idle_s) begin
          if (idle_r == IDLE_LAST) begin
            sel_nxt_s   = req_s;
            idle_nxt_s  = '0;
            state_nxt_s = ST_ACTIVE;
          end else begin
            idle_nxt_s  = idle_r + IDLE_ONE;
          end
        end else begin
          idle_nxt_s = '0;
        end
      end
      default: begin
        state_nxt_s = ST_ACTIVE;
        idle_nxt_s  = '0;
      end
    endcase
  end

  assign o_uart_tx = uart_tx_r;
  assign o_tx_sel  = sel_r;

endmodule

// File: tb/tb_veerwolf_board_io.sv
// Directed self-checking bench for veerwolf_board_io (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, IDLE_CYCLES=8, HEARTBEAT_CYCLES=10).
module tb_veerwolf_board_io;

  logic        clk;
  logic        rst;
  logic [15:0] i_sw;
  logic [15:0] o_sw;
  logic [15:0] o_sw_rise;
  logic [15:0] o_sw_fall;
  logic [15:0] i_led;
  logic [15:0] o_led;
  logic        i_tx_a;
  logic        i_tx_b;
  logic        o_uart_tx;
  logic        o_tx_sel;

  int checks;
  int errors;

`ifdef VEERWOLF_BOARD_IO_HEARTBEAT_EN
  localparam logic [15:0] LED_MASK = 16'h7FFF;
`else
  localparam logic [15:0] LED_MASK = 16'hFFFF;
`endif

  veerwolf_board_io #(
    .SW_WIDTH(16), .LED_WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .UART_SEL_BIT(0), .IDLE_CYCLES(8), .HEARTBEAT_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .i_sw(i_sw), .o_sw(o_sw), .o_sw_rise(o_sw_rise),
    .o_sw_fall(o_sw_fall), .i_led(i_led), .o_led(o_led), .i_tx_a(i_tx_a),
    .i_tx_b(i_tx_b), .o_uart_tx(o_uart_tx), .o_tx_sel(o_tx_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_sw = 16'hFFFF; i_led = 16'hFFFF; i_tx_a = 1'b1; i_tx_b = 1'b1;
    repeat (3) tick();
    checks++;
    if (o_sw !== 16'h0000 || o_sw_rise !== 16'h0000 || o_sw_fall !== 16'h0000) begin
      errors++; $display("FAIL reset_sw: o_sw=%h rise=%h fall=%h, expected all 0", o_sw, o_sw_rise, o_sw_fall);
    end
    checks++;
    if (o_led !== 16'h0000) begin
      errors++; $display("FAIL reset_led: o_led=%h expected 0000", o_led);
    end
    checks++;
    if (o_uart_tx !== 1'b1 || o_tx_sel !== 1'b0) begin
      errors++; $display("FAIL reset_tx: uart_tx=%b tx_sel=%b expected 1/0", o_uart_tx, o_tx_sel);
    end
    i_sw = 16'h0000; i_led = 16'h0000;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (o_sw !== 16'h0000 || o_led !== 16'h0000) begin
      errors++; $display("FAIL post_reset_idle: o_sw=%h o_led=%h expected 0", o_sw, o_led);
    end
  endtask

  task automatic test_clean_edge();
    i_sw[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (o_sw !== ((k >= 6) ? 16'h0008 : 16'h0000)) begin
        errors++; $display("FAIL edge_sw k=%0d: o_sw=%h expected %h", k, o_sw, (k >= 6) ? 16'h0008 : 16'h0000);
      end
      checks++;
      if (o_sw_rise !== ((k == 6) ? 16'h0008 : 16'h0000) || o_sw_fall !== 16'h0000) begin
        errors++; $display("FAIL edge_pulse k=%0d: rise=%h fall=%h", k, o_sw_rise, o_sw_fall);
      end
    end
  endtask

  task automatic test_bounce();
    int rises;
    rises = 0;
    for (int b = 0; b < 4; b++) begin
      i_sw[5] = (b % 2 == 0) ? 1'b1 : 1'b0;
      repeat (2) begin
        tick();
        if (o_sw_rise[5] === 1'b1) rises++;
        checks++;
        if (o_sw !== 16'h0008) begin
          errors++; $display("FAIL bounce_hold: o_sw=%h expected 0008", o_sw);
        end
      end
    end
    i_sw[5] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (o_sw_rise[5] === 1'b1) rises++;
      checks++;
      if (o_sw !== ((k >= 6) ? 16'h0028 : 16'h0008)) begin
        errors++; $display("FAIL bounce_settle k=%0d: o_sw=%h", k, o_sw);
      end
    end
    checks++;
    if (rises != 1) begin
      errors++; $display("FAIL bounce_rise_count: got %0d expected 1", rises);
    end
  endtask

  task automatic test_led_pipeline();
    i_led = 16'hA5A5;
    tick();
    checks++;
    if ((o_led & LED_MASK) !== 16'h0000) begin
      errors++; $display("FAIL led_n1: o_led=%h expected 0000", o_led);
    end
    i_led = 16'h5A5A;
    tick();
    checks++;
    if ((o_led & LED_MASK) !== (16'hA5A5 & LED_MASK)) begin
      errors++; $display("FAIL led_n2: o_led=%h expected a5a5", o_led);
    end
    tick();
    checks++;
    if ((o_led & LED_MASK) !== (16'h5A5A & LED_MASK)) begin
      errors++; $display("FAIL led_next: o_led=%h expected 5a5a", o_led);
    end
  endtask

  task automatic test_tx_switchover();
    i_tx_a = 1'b0;
    i_sw[0] = 1'b1;
    repeat (6) tick();
    checks++;
    if (o_sw[0] !== 1'b1) begin
      errors++; $display("FAIL tx_req: o_sw[0]=%b expected 1", o_sw[0]);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (o_tx_sel !== 1'b0 || o_uart_tx !== 1'b0) begin
        errors++; $display("FAIL tx_busy k=%0d: sel=%b uart=%b expected 0/0", k, o_tx_sel, o_uart_tx);
      end
    end
    i_tx_a = 1'b1;
    repeat (3) tick();
    i_tx_a = 1'b0;
    tick();
    checks++;
    if (o_tx_sel !== 1'b0) begin
      errors++; $display("FAIL tx_glitch: sel=%b expected 0", o_tx_sel);
    end
    i_tx_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (o_tx_sel !== ((k == 8) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL tx_idle_count k=%0d: sel=%b", k, o_tx_sel);
      end
    end
    i_tx_b = 1'b0;
    tick();
    checks++;
    if (o_uart_tx !== 1'b0) begin
      errors++; $display("FAIL tx_follow_b0: uart=%b expected 0", o_uart_tx);
    end
    i_tx_b = 1'b1; i_tx_a = 1'b0;
    tick();
    checks++;
    if (o_uart_tx !== 1'b1) begin
      errors++; $display("FAIL tx_follow_b1: uart=%b expected 1", o_uart_tx);
    end
  endtask

  task automatic test_tx_retract();
    i_tx_a = 1'b0;
    i_sw[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 6) begin
        checks++;
        if (o_sw_fall[0] !== 1'b1 || o_sw_rise[0] !== 1'b0 || o_sw[0] !== 1'b0) begin
          errors++; $display("FAIL retract_fall: fall=%b rise=%b sw=%b", o_sw_fall[0], o_sw_rise[0], o_sw[0]);
        end
      end
    end
    repeat (3) tick();
    i_sw[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (o_tx_sel !== 1'b1) begin
        errors++; $display("FAIL retract_drain k=%0d: sel=%b expected 1", k, o_tx_sel);
      end
    end
    i_tx_a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (o_tx_sel !== 1'b1) begin
        errors++; $display("FAIL retract_idle k=%0d: sel=%b expected 1", k, o_tx_sel);
      end
    end
  endtask

  task automatic test_heartbeat();
    i_led = 16'h0000;
    repeat (2) tick();
`ifdef VEERWOLF_BOARD_IO_HEARTBEAT_EN
    begin
      logic prev;
      int   waited;
      prev = o_led[15];
      waited = 0;
      while (o_led[15] === prev && waited < 12) begin
        tick();
        waited++;
      end
      checks++;
      if (o_led[15] === prev) begin
        errors++; $display("FAIL hb_first: no toggle within 12 cycles, led15=%b", o_led[15]);
      end
      prev = o_led[15];
      for (int k = 1; k <= 10; k++) begin
        tick();
        checks++;
        if (o_led[15] !== ((k == 10) ? ~prev : prev) || o_led[14:0] !== 15'h0000) begin
          errors++; $display("FAIL hb_period k=%0d: o_led=%h", k, o_led);
        end
      end
    end
`else
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++;
      if (o_led !== 16'h0000) begin
        errors++; $display("FAIL no_hb k=%0d: o_led=%h expected 0000", k, o_led);
      end
    end
`endif
  endtask

  task automatic test_mid_reset();
    i_led = 16'h1234;
    i_sw[0] = 1'b0;
    i_tx_a = 1'b0;
    repeat (8) tick();
    i_sw[7] = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (o_sw !== 16'h0000 || o_sw_rise !== 16'h0000 || o_sw_fall !== 16'h0000) begin
      errors++; $display("FAIL midrst_sw: o_sw=%h rise=%h fall=%h", o_sw, o_sw_rise, o_sw_fall);
    end
    checks++;
    if (o_led !== 16'h0000 || o_uart_tx !== 1'b1 || o_tx_sel !== 1'b0) begin
      errors++; $display("FAIL midrst_out: o_led=%h uart=%b sel=%b", o_led, o_uart_tx, o_tx_sel);
    end
    i_sw = 16'h0000; i_led = 16'h0000; i_tx_a = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    checks++;
    if (o_sw !== 16'h0000 || o_tx_sel !== 1'b0 || o_uart_tx !== 1'b1) begin
      errors++; $display("FAIL midrst_after: o_sw=%h sel=%b uart=%b", o_sw, o_tx_sel, o_uart_tx);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clean_edge();
    test_bounce();
    test_led_pipeline();
    test_tx_switchover();
    test_tx_retract();
    test_heartbeat();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
